// File: rtl/cms_sched_pkg.sv
// Shared types and widths for the CMS job scheduler.
package cms_sched_pkg;
  localparam int CMS_DATA_W = 32;
  localparam int CMS_RES_W  = 64;
  localparam int LOG2_W     = 3;
  localparam int CNT_W      = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_INIT,
    S_STREAM,
    S_WAIT_RES,
    S_DONE
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);
  int w_c;

  // Scan from farthest to nearest so the closest requester to the pointer wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_c = (int'(i_ptr) + k) % NUM_CH;
      if (i_req[IDX_W'(w_c)]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(w_c);
        o_gnt = '0;
        o_gnt[IDX_W'(w_c)] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cms_job_scheduler.sv
// Round-robin sharing of one complex_mean_square unit among NUM_CH requesters:
// grant, en pulse, init cycle, gap-free N-sample burst, result capture or timeout.
module cms_job_scheduler
  import cms_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TMO_CYC = 16
) (
  input  logic                         i_clk,
  input  logic                         i_arst,
  input  logic                         i_en,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [LOG2_W*NUM_CH-1:0]     i_req_log2,
  input  logic [NUM_CH-1:0]            i_smp_valid,
  input  logic [CMS_DATA_W*NUM_CH-1:0] i_y,
  input  logic [CMS_DATA_W*NUM_CH-1:0] i_y_hat,
  output logic [NUM_CH-1:0]            o_smp_ready,
  output logic [NUM_CH-1:0]            o_done,
  output logic [CMS_RES_W-1:0]         o_result,
  output logic                         o_timeout,
  output logic                         o_busy,
  output logic                         o_cms_en,
  output logic [LOG2_W-1:0]            o_cms_log2,
  output logic                         o_cms_valid,
  output logic [CMS_DATA_W-1:0]        o_cms_y,
  output logic [CMS_DATA_W-1:0]        o_cms_y_hat,
  input  logic                         i_cms_valid,
  input  logic [CMS_RES_W-1:0]         i_cms_data
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_ch, r_ptr, w_win_idx;
  logic [NUM_CH-1:0]     r_gnt, w_win_gnt;
  logic                  w_win_any, w_grant;
  logic [LOG2_W-1:0]     r_log2, w_win_log2;
  logic [CNT_W-1:0]      r_cnt, w_n;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic                  r_tmo_flag, r_underrun;
  logic [CMS_RES_W-1:0]  r_result;
  logic [CMS_DATA_W-1:0] w_y_sel, w_yh_sel;
  logic                  w_vld_sel, w_last_smp, w_tmo_hit;
  logic                  w_unused_dbg;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_win_gnt),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  assign w_grant      = (r_state == S_IDLE) && i_en && w_win_any;
  assign w_n          = CNT_W'(1) << r_log2;
  assign w_last_smp   = (r_cnt == w_n - CNT_W'(1));
  assign w_tmo_hit    = (r_tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign o_result     = r_result;
  // Underrun is a debug-only observation; it never alters the job.
  assign w_unused_dbg = r_underrun;

  always_comb begin
    w_win_log2 = '0;
    w_y_sel    = '0;
    w_yh_sel   = '0;
    w_vld_sel  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_win_idx == IDX_W'(c)) w_win_log2 = i_req_log2[LOG2_W*c +: LOG2_W];
      if (r_ch == IDX_W'(c)) begin
        w_y_sel   = i_y[CMS_DATA_W*c +: CMS_DATA_W];
        w_yh_sel  = i_y_hat[CMS_DATA_W*c +: CMS_DATA_W];
        w_vld_sel = i_smp_valid[c];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cms_en    = 1'b0;
    o_cms_valid = 1'b0;
    o_cms_log2  = '0;
    o_cms_y     = '0;
    o_cms_y_hat = '0;
    o_smp_ready = '0;
    o_done      = '0;
    o_timeout   = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (w_grant) w_state_nxt = S_START;
      S_START: begin
        o_cms_en    = 1'b1;
        o_cms_log2  = r_log2;
        w_state_nxt = S_INIT;
      end
      S_INIT: begin
        o_cms_log2  = r_log2;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        o_cms_valid = 1'b1;
        o_cms_log2  = r_log2;
        o_smp_ready = r_gnt;
        // A missing sample is replaced by zero so the burst stays gap-free.
        if (w_vld_sel) begin
          o_cms_y     = w_y_sel;
          o_cms_y_hat = w_yh_sel;
        end
        if (w_last_smp) w_state_nxt = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        o_cms_log2 = r_log2;
        if (i_cms_valid || w_tmo_hit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = r_gnt;
        o_timeout   = r_tmo_flag;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_ch       <= '0;
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_log2     <= '0;
      r_cnt      <= '0;
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
      r_underrun <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_ch       <= w_win_idx;
          r_gnt      <= w_win_gnt;
          r_log2     <= w_win_log2;
          r_tmo_flag <= 1'b0;
          r_underrun <= 1'b0;
        end
        S_START: begin
          r_cnt     <= '0;
          r_tmo_cnt <= '0;
        end
        S_STREAM: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!w_vld_sel) r_underrun <= 1'b1;
        end
        S_WAIT_RES: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (i_cms_valid) begin
            r_result <= i_cms_data;
          end else if (w_tmo_hit) begin
            r_result   <= '0;
            r_tmo_flag <= 1'b1;
          end
        end
        S_DONE: r_ptr <= (r_ch == IDX_W'(NUM_CH - 1)) ? '0 : r_ch + IDX_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cms_job_scheduler.sv
// Scoreboard bench for cms_job_scheduler with a behavioural CMS unit model.
module tb_cms_job_scheduler;
  localparam int NUM_CH  = 4;
  localparam int TMO_CYC = 16;

  logic                   i_clk = 1'b0;
  logic                   i_arst;
  logic                   i_en;
  logic [NUM_CH-1:0]      i_req;
  logic [3*NUM_CH-1:0]    i_req_log2;
  logic [NUM_CH-1:0]      i_smp_valid;
  logic [32*NUM_CH-1:0]   i_y;
  logic [32*NUM_CH-1:0]   i_y_hat;
  logic [NUM_CH-1:0]      o_smp_ready;
  logic [NUM_CH-1:0]      o_done;
  logic [63:0]            o_result;
  logic                   o_timeout;
  logic                   o_busy;
  logic                   o_cms_en;
  logic [2:0]             o_cms_log2;
  logic                   o_cms_valid;
  logic [31:0]            o_cms_y;
  logic [31:0]            o_cms_y_hat;
  logic                   i_cms_valid;
  logic [63:0]            i_cms_data;

  always #5 i_clk = ~i_clk;

  cms_job_scheduler #(.NUM_CH(NUM_CH), .TMO_CYC(TMO_CYC)) dut (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_en        (i_en),
    .i_req       (i_req),
    .i_req_log2  (i_req_log2),
    .i_smp_valid (i_smp_valid),
    .i_y         (i_y),
    .i_y_hat     (i_y_hat),
    .o_smp_ready (o_smp_ready),
    .o_done      (o_done),
    .o_result    (o_result),
    .o_timeout   (o_timeout),
    .o_busy      (o_busy),
    .o_cms_en    (o_cms_en),
    .o_cms_log2  (o_cms_log2),
    .o_cms_valid (o_cms_valid),
    .o_cms_y     (o_cms_y),
    .o_cms_y_hat (o_cms_y_hat),
    .i_cms_valid (i_cms_valid),
    .i_cms_data  (i_cms_data)
  );

  typedef struct {
    int          ch;
    logic [63:0] res;
    bit          tmo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  bit   no_resp = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural CMS: complex square of (y - y_hat), summed, arithmetic shift by log2.
  logic signed [16:0] er, ei;
  longint sq_re, sq_im, acc_re, acc_im;
  int     m_cnt;
  bit     m_dly;

  always_comb begin
    er    = $signed({o_cms_y[31], o_cms_y[31:16]}) - $signed({o_cms_y_hat[31], o_cms_y_hat[31:16]});
    ei    = $signed({o_cms_y[15], o_cms_y[15:0]}) - $signed({o_cms_y_hat[15], o_cms_y_hat[15:0]});
    sq_re = longint'(er) * longint'(er) - longint'(ei) * longint'(ei);
    sq_im = 2 * longint'(er) * longint'(ei);
  end

  always @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      acc_re <= 0; acc_im <= 0; m_cnt <= 0; m_dly <= 1'b0;
      i_cms_valid <= 1'b0; i_cms_data <= '0;
    end else begin
      i_cms_valid <= 1'b0;
      if (o_cms_en) begin
        acc_re <= 0; acc_im <= 0; m_cnt <= 0; m_dly <= 1'b0;
      end else if (o_cms_valid) begin
        acc_re <= acc_re + sq_re;
        acc_im <= acc_im + sq_im;
        m_cnt  <= m_cnt + 1;
        if (m_cnt + 1 == (1 << o_cms_log2)) m_dly <= 1'b1;
      end else if (m_dly) begin
        m_dly <= 1'b0;
        if (!no_resp) begin
          i_cms_valid <= 1'b1;
          i_cms_data  <= {32'(acc_re >>> o_cms_log2), 32'(acc_im >>> o_cms_log2)};
        end
      end
    end
  end

  always @(posedge i_clk) cyc++;

  // Monitor: every o_done pulse is matched against the oldest expected job.
  always @(negedge i_clk) begin
    if (!i_arst) begin
      if (o_cms_en) en_cyc = cyc;
      if (|o_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: o_done=%b with nothing expected", o_done);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_ch", 64'(o_done), 64'(1 << mon_e.ch));
          chk("result", o_result, mon_e.res);
          chk("timeout", 64'(o_timeout), 64'(mon_e.tmo));
          chk("latency_from_en", 64'(cyc - en_cyc), 64'(mon_e.lat));
        end
      end
    end
  end

  task automatic wait_ready(input int ch);
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge i_clk);
      if (o_smp_ready[ch]) ok = 1'b1;
    end
    chk($sformatf("wait_ready_ch%0d", ch), 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge i_clk);
      if (!o_busy) ok = 1'b1;
    end
    chk("wait_idle", 64'(ok), 64'd1);
  endtask

  task automatic set_ch(input int ch, input int lg, input logic [31:0] y, input logic [31:0] yh);
    i_req_log2[3*ch +: 3] = 3'(lg);
    i_y[32*ch +: 32]      = y;
    i_y_hat[32*ch +: 32]  = yh;
  endtask

  task automatic push_exp(input int ch, input logic [63:0] res, input bit tmo, input int lat);
    exp_t e;
    e.ch = ch; e.res = res; e.tmo = tmo; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic job(input int ch, input int lg, input logic [31:0] y, input logic [31:0] yh,
                     input logic [63:0] res, input bit tmo, input int lat);
    set_ch(ch, lg, y, yh);
    push_exp(ch, res, tmo, lat);
    i_req[ch] = 1'b1;
    wait_ready(ch);
    i_req[ch] = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    i_arst = 1'b1; i_en = 1'b1; i_req = '0; i_req_log2 = '0;
    i_smp_valid = '1; i_y = '0; i_y_hat = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_ready", 64'(o_smp_ready), 64'd0);
    chk("rst_result", o_result, 64'd0);
    chk("rst_cms_en", 64'(o_cms_en), 64'd0);
    chk("rst_cms_valid", 64'(o_cms_valid), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    chk("rst_cms_log2", 64'(o_cms_log2), 64'd0);
    @(posedge i_clk); #1 i_arst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_busy", 64'(o_busy), 64'd0);

    // 4 x 3^2 / 4 = 9; done 8 cycles after en (grant + 9)
    job(0, 2, 32'h0003_0000, 32'h0, 64'h00000009_00000000, 1'b0, 8);
    chk("underrun_clean", 64'(dut.r_underrun), 64'd0);

    // (1+j)^2 = 2j
    job(2, 0, 32'h0001_0001, 32'h0, 64'h00000000_00000002, 1'b0, 5);

    // Second burst sample missing: 3 x 16 / 4 = 12
    set_ch(0, 2, 32'h0004_0000, 32'h0);
    push_exp(0, 64'h0000000C_00000000, 1'b0, 8);
    i_req[0] = 1'b1;
    wait_ready(0);
    i_req[0] = 1'b0;
    @(posedge i_clk); #1 i_smp_valid[0] = 1'b0;
    @(posedge i_clk); #1 i_smp_valid[0] = 1'b1;
    wait_idle();
    chk("underrun_flag", 64'(dut.r_underrun), 64'd1);

    // CMS silent: done after TMO_CYC cycles in WAIT_RES
    no_resp = 1'b1;
    job(1, 0, 32'h0007_0000, 32'h0, 64'h0, 1'b1, 19);
    no_resp = 1'b0;

    // Reset mid-burst
    set_ch(0, 7, 32'h0001_0000, 32'h0);
    i_req[0] = 1'b1;
    wait_ready(0);
    i_req[0] = 1'b0;
    repeat (5) @(negedge i_clk);
    @(posedge i_clk); #1 i_arst = 1'b1;
    #2 i_arst = 1'b0;
    @(negedge i_clk);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_ready", 64'(o_smp_ready), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_cms_valid", 64'(o_cms_valid), 64'd0);

    // Pointer 0, ch1 and ch3 together; ch1 keeps requesting -> 1, 3, 1
    set_ch(1, 1, 32'h0005_0000, 32'h0003_0000);
    set_ch(3, 3, 32'h0000_0003, 32'h0);
    push_exp(1, 64'h00000004_00000000, 1'b0, 6);
    push_exp(3, 64'hFFFFFFF7_00000000, 1'b0, 12);
    push_exp(1, 64'h00000004_00000000, 1'b0, 6);
    i_req[1] = 1'b1; i_req[3] = 1'b1;
    wait_ready(1);
    wait_idle();
    wait_ready(3);
    i_req[3] = 1'b0;
    wait_ready(1);
    i_req[1] = 1'b0;
    wait_idle();

    job(2, 0, 32'h0001_0001, 32'h0, 64'h00000000_00000002, 1'b0, 5);

    // Disabled: request must be held off, then served once enabled
    i_en = 1'b0;
    set_ch(0, 0, 32'h0002_0000, 32'h0001_0000);
    i_req[0] = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_busy) seen = 1'b1;
    end
    chk("no_grant_en0", 64'(seen), 64'd0);
    push_exp(0, 64'h00000001_00000000, 1'b0, 5);
    i_en = 1'b1;
    wait_ready(0);
    i_req[0] = 1'b0;
    wait_idle();

    repeat (5) @(negedge i_clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
